// File: rtl/compressor_pkg.sv
// Shared LZRW1 types and constants: item word, history geometry, copy length
// bias and the decompressor state encoding.
package compressor_pkg;

    typedef logic [15:0] data_in_t;

    localparam int TABLESIZE    = 4096;
    localparam int OFFSET_W     = $clog2(TABLESIZE);
    localparam int MIN_COPY_LEN = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        COPY = 1'b1
    } state_t;

    // len_code 0..15 maps to 3..18 bytes, which needs 5 bits.
    function automatic logic [4:0] copy_len(input logic [3:0] len_code);
        return {1'b0, len_code} + 5'(MIN_COPY_LEN);
    endfunction

endpackage

// File: rtl/lzrw1_decomp_core_if.sv
// Decompressor item bus: the source presents items, the core returns bytes.
// decomp_err exists only when LZRW1_DECOMP_ERR_EN is defined.
interface lzrw1_decomp_core_if;
  import compressor_pkg::*;

  data_in_t     data_in;
  logic         control_word_in;
  logic         data_in_valid;
  logic [7:0]   decompressed_byte;
  logic         out_valid;
  logic         decompressor_busy;
`ifdef LZRW1_DECOMP_ERR_EN
  logic         decomp_err;
`endif

  modport master (
    output data_in, control_word_in, data_in_valid,
`ifdef LZRW1_DECOMP_ERR_EN
    input  decomp_err,
`endif
    input  decompressed_byte, out_valid, decompressor_busy
  );

  modport slave (
    input  data_in, control_word_in, data_in_valid,
`ifdef LZRW1_DECOMP_ERR_EN
    output decomp_err,
`endif
    output decompressed_byte, out_valid, decompressor_busy
  );

endinterface

// File: rtl/lzrw1_hist_ram.sv
// History buffer: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module lzrw1_hist_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lzrw1_decomp_core.sv
// LZRW1 decompressor: expands literal/copy items into one byte per cycle.
// Optional offset checking with sticky decomp_err under LZRW1_DECOMP_ERR_EN.
module lzrw1_decomp_core
  import compressor_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  lzrw1_decomp_core_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_COPY = COPY;

  logic [0:0]          state_reg;
  logic [OFFSET_W-1:0] wptr_reg;
  logic [OFFSET_W-1:0] src_reg;
  logic [4:0]          rem_reg;
  logic [7:0]          byte_reg;
  logic                valid_reg;

  logic                accept;
  logic                is_copy;
  logic [OFFSET_W-1:0] offset;
  logic [3:0]          len_code;
  logic                copy_bad;
  logic                hist_we;
  logic [7:0]          hist_wdata;
  logic [7:0]          hist_rdata;

  assign accept   = bus.data_in_valid && (state_reg == ST_IDLE);
  assign is_copy  = bus.control_word_in;
  assign offset   = bus.data_in[OFFSET_W-1:0];
  assign len_code = bus.data_in[15:12];

  // Both literals and replayed bytes land at wptr; the read port feeds the copy.
  assign hist_we    = (accept && !is_copy) || (state_reg == ST_COPY);
  assign hist_wdata = (state_reg == ST_COPY) ? hist_rdata : bus.data_in[7:0];

  lzrw1_hist_ram #(
    .DEPTH (TABLESIZE),
    .AW    (OFFSET_W)
  ) u_hist (
    .clock (clock),
    .we    (hist_we),
    .waddr (wptr_reg),
    .wdata (hist_wdata),
    .raddr (src_reg),
    .rdata (hist_rdata)
  );

`ifdef LZRW1_DECOMP_ERR_EN
  logic [12:0] count_reg;
  logic        err_reg;

  // Offsets reaching before the first byte ever written are rejected.
  assign copy_bad = (offset == '0) || ({1'b0, offset} > count_reg);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (hist_we && (count_reg != 13'h1FFF)) begin
        count_reg <= count_reg + 13'd1;
      end
      if (accept && is_copy && copy_bad) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign bus.decomp_err = err_reg;
`else
  assign copy_bad = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      wptr_reg  <= '0;
      src_reg   <= '0;
      rem_reg   <= '0;
      byte_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (!is_copy) begin
              byte_reg  <= bus.data_in[7:0];
              valid_reg <= 1'b1;
              wptr_reg  <= wptr_reg + 1'b1;
            end else if (!copy_bad) begin
              src_reg   <= wptr_reg - offset;
              rem_reg   <= copy_len(len_code);
              state_reg <= ST_COPY;
            end
          end
        end
        ST_COPY: begin
          byte_reg  <= hist_rdata;
          valid_reg <= 1'b1;
          wptr_reg  <= wptr_reg + 1'b1;
          src_reg   <= src_reg + 1'b1;
          rem_reg   <= rem_reg - 5'd1;
          if (rem_reg == 5'd1) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.decompressed_byte = byte_reg;
  assign bus.out_valid         = valid_reg;
  assign bus.decompressor_busy = (state_reg != ST_IDLE);

endmodule
